// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks i/j/k for one N x N signed matrix multiply C = A x B.
// It reads A and B from single-port banks, multiply-accumulates with a one-cycle
// read pipeline, writes one C element every N+2 cycles and then pulses done.
//
// Strobe semantics: a bank read is issued in any cycle where mem_x_rd_en=1, and
// its data is valid on mem_x_rdata in the following cycle. A C write happens in
// any cycle where mem_c_wr_en=1. Addresses and write data are meaningful only
// while their strobe is high. The banks never back-pressure. Read and write
// strobes are never high in the same cycle.
module matmul_sequencer #(
    parameter int N      = 64,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 22
) (
    input  logic              clk,
    input  logic              rstn,          // active-high synchronous reset
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_a_rd_en,
    output logic [ADDR_W-1:0] mem_a_addr,
    input  logic [DATA_W-1:0] mem_a_rdata,
    output logic              mem_b_rd_en,
    output logic [ADDR_W-1:0] mem_b_addr,
    input  logic [DATA_W-1:0] mem_b_rdata,
    output logic              mem_c_wr_en,
    output logic [ADDR_W-1:0] mem_c_addr,
    output logic [ACC_W-1:0]  mem_c_wdata,
    output logic [2:0]        o_dbg_state
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [IDX_W-1:0]         r_i;
    logic [IDX_W-1:0]         r_j;
    logic [IDX_W-1:0]         r_k;
    logic                     r_pv;      // read data returning this cycle
    logic [IDX_W-1:0]         r_pk;      // k of the returning read
    logic signed [ACC_W-1:0]  r_acc;

    logic                     w_last_k;
    logic                     w_last_ij;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;

    assign w_last_k  = (r_k == IDX_MAX);
    assign w_last_ij = (r_i == IDX_MAX) && (r_j == IDX_MAX);

    // N is a power of two, so r*N+c is just the concatenation {r, c}.
    assign mem_a_addr  = ADDR_W'({r_i, r_k});
    assign mem_b_addr  = ADDR_W'({r_k, r_j});
    assign mem_c_addr  = ADDR_W'({r_i, r_j});
    assign mem_c_wdata = r_acc;
    assign o_dbg_state = r_state;

    // Full-precision signed product, sign-extended to the accumulator width.
    assign w_prod     = $signed(mem_a_rdata) * $signed(mem_b_rdata);
    assign w_prod_ext = ACC_W'(w_prod);

    // State register.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs decoded from the current state.
    always_comb begin
        w_next      = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_a_rd_en = 1'b0;
        mem_b_rd_en = 1'b0;
        mem_c_wr_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy        = 1'b1;
                mem_a_rd_en = 1'b1;
                mem_b_rd_en = 1'b1;
                if (w_last_k) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy   = 1'b1;
                w_next = S_WRITE;
            end
            S_WRITE: begin
                busy        = 1'b1;
                mem_c_wr_en = 1'b1;
                w_next      = w_last_ij ? S_DONE : S_RUN;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Loop counters: k steps every RUN cycle, j/i advance once per written element.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_i <= '0;
                    r_j <= '0;
                    r_k <= '0;
                end
                S_RUN: begin
                    r_k <= r_k + 1'b1;
                end
                S_WRITE: begin
                    r_k <= '0;
                    if (r_j == IDX_MAX) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read pipeline tag: marks the cycle in which bank data returns, and its k.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_pv <= 1'b0;
            r_pk <= '0;
        end else begin
            r_pv <= (r_state == S_RUN);
            r_pk <= r_k;
        end
    end

    // Accumulator: restarts on k=0 data, wraps modulo 2^ACC_W otherwise.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_acc <= '0;
        end else if (r_pv) begin
            if (r_pk == '0) begin
                r_acc <= w_prod_ext;
            end else begin
                r_acc <= r_acc + w_prod_ext;
            end
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Testbench for matmul_sequencer at N=4: bank models, scoreboard of expected
// C writes, directed runs covering timing, restart, mid-run reset and held start.
module tb_matmul_sequencer;

    localparam int TN = 4;
    localparam int TA = 4;
    localparam int TD = 8;
    localparam int TC = 22;
    localparam int NN = TN * TN;
    localparam int DONE_CYC = NN * (TN + 2) + 1;   // 97

    logic          clk;
    logic          rstn;
    logic          start;
    logic          busy;
    logic          done;
    logic          mem_a_rd_en;
    logic [TA-1:0] mem_a_addr;
    logic [TD-1:0] mem_a_rdata;
    logic          mem_b_rd_en;
    logic [TA-1:0] mem_b_addr;
    logic [TD-1:0] mem_b_rdata;
    logic          mem_c_wr_en;
    logic [TA-1:0] mem_c_addr;
    logic [TC-1:0] mem_c_wdata;
    logic [2:0]    dbg_state;

    logic signed [TD-1:0] mem_a [NN];
    logic signed [TD-1:0] mem_b [NN];

    logic [TA+TC-1:0] exp_q[$];
    int checks;
    int errors;

    matmul_sequencer #(.N(TN), .ADDR_W(TA), .DATA_W(TD), .ACC_W(TC)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mem_a_rd_en (mem_a_rd_en),
        .mem_a_addr  (mem_a_addr),
        .mem_a_rdata (mem_a_rdata),
        .mem_b_rd_en (mem_b_rd_en),
        .mem_b_addr  (mem_b_addr),
        .mem_b_rdata (mem_b_rdata),
        .mem_c_wr_en (mem_c_wr_en),
        .mem_c_addr  (mem_c_addr),
        .mem_c_wdata (mem_c_wdata),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rstn  = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
    endtask

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- bank models (1-cycle read latency) ----------------
    always @(posedge clk) begin
        if (mem_a_rd_en) mem_a_rdata <= mem_a[mem_a_addr];
        if (mem_b_rd_en) mem_b_rdata <= mem_b[mem_b_addr];
    end

    // ---------------- monitor: pops expected C writes ----------------
    always @(negedge clk) begin
        if (mem_c_wr_en === 1'b1) begin
            chk("strobe_excl", {mem_a_rd_en, mem_b_rd_en}, 2'b00);
            if (exp_q.size() == 0) begin
                chk("unexpected_c_write", {mem_c_addr, mem_c_wdata}, '0);
            end else begin
                chk("c_write", {mem_c_addr, mem_c_wdata}, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_model(input int count);
        for (int e = 0; e < count; e++) begin
            int s;
            logic [TC-1:0] v;
            s = 0;
            for (int k = 0; k < TN; k++) begin
                s += int'(mem_a[(e / TN) * TN + k]) * int'(mem_b[k * TN + (e % TN)]);
            end
            v = s[TC-1:0];
            exp_q.push_back({TA'(e), v});
        end
    endtask

    task automatic push_const(input logic [TC-1:0] v);
        for (int e = 0; e < NN; e++) exp_q.push_back({TA'(e), v});
    endtask

    task automatic fill_random();
        for (int e = 0; e < NN; e++) begin
            mem_a[e] = TD'($urandom_range(0, 255));
            mem_b[e] = TD'($urandom_range(0, 255));
        end
    endtask

    // Pulse start, wait for done (bounded), check its cycle, then quiet cycles.
    // With repulse, start is pulsed again during a RUN and a WRITE cycle.
    task automatic run_and_check(input string name, input bit repulse);
        int  n;
        bit  found;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 1;
        found = 1'b0;
        while (n <= 300 && !found) begin
            if (repulse) begin
                start = (n == 2 || n == 6);
                if (n == 2) chk({name, "_run_state"}, dbg_state, 3'd1);
                if (n == 6) chk({name, "_write_state"}, dbg_state, 3'd3);
            end
            if (done === 1'b1) begin
                found = 1'b1;
                chk({name, "_done_cycle"}, n, DONE_CYC);
                chk({name, "_busy_at_done"}, busy, 1'b0);
            end else begin
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        if (!found) chk({name, "_done_timeout"}, 0, 1);
        for (int q = 0; q < 4; q++) begin
            @(negedge clk);
            chk({name, "_quiet_after_done"}, {busy, done}, 2'b00);
        end
        chk({name, "_all_writes_seen"}, exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  n;
        bit  found;
        checks = 0;
        errors = 0;
        rstn   = 1'b1;
        start  = 1'b0;
        do_reset();

        // reset state
        chk("rst_busy",  busy, 1'b0);
        chk("rst_done",  done, 1'b0);
        chk("rst_rd_en", {mem_a_rd_en, mem_b_rd_en}, 2'b00);
        chk("rst_wr_en", mem_c_wr_en, 1'b0);
        chk("rst_state", dbg_state, 3'd0);
        @(negedge clk);
        chk("idle_no_start", dbg_state, 3'd0);

        // identity x B: C equals B, written at 0..15 in order
        for (int e = 0; e < NN; e++) begin
            mem_a[e] = ((e / TN) == (e % TN)) ? 8'sd1 : 8'sd0;
            mem_b[e] = TD'(e);
            exp_q.push_back({TA'(e), TC'(e)});
        end
        run_and_check("identity", 1'b0);

        // all -128: 4 * 16384 = 65536
        for (int e = 0; e < NN; e++) begin
            mem_a[e] = -8'sd128;
            mem_b[e] = -8'sd128;
        end
        push_const(22'h010000);
        run_and_check("neg128_sq", 1'b0);

        // -128 x 127: 4 * -16256 = -65024
        for (int e = 0; e < NN; e++) mem_b[e] = 8'sd127;
        push_const(22'h3F0200);
        run_and_check("neg128_x127", 1'b0);

        // random data against the golden model, with start re-pulsed mid-run
        fill_random();
        push_model(NN);
        run_and_check("random_repulse", 1'b1);

        // reset during the WRITE of element 5 (cycle 36)
        fill_random();
        push_model(6);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 1;
        while (n < 36) begin
            @(negedge clk);
            n++;
        end
        chk("abort_in_write", {dbg_state, mem_c_wr_en}, {3'd3, 1'b1});
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        chk("abort_no_write", mem_c_wr_en, 1'b0);
        chk("abort_busy_done", {busy, done}, 2'b00);
        chk("abort_no_read", {mem_a_rd_en, mem_b_rd_en}, 2'b00);
        chk("abort_writes_seen", exp_q.size(), 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_stays_idle", {busy, done, mem_c_wr_en}, 3'b000);
        end
        push_model(NN);
        run_and_check("after_abort", 1'b0);

        // start held high: back-to-back runs
        fill_random();
        push_model(NN);
        push_model(NN);
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        n = 1;
        found = 1'b0;
        while (n <= 300 && !found) begin
            if (done === 1'b1) found = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("held_first_done", n, DONE_CYC);
        @(negedge clk);
        chk("held_idle_gap", {busy, dbg_state}, {1'b0, 3'd0});
        @(negedge clk);
        chk("held_restart_busy", busy, 1'b1);
        chk("held_restart_rd", {mem_a_rd_en, mem_b_rd_en}, 2'b11);
        chk("held_restart_addr", {mem_a_addr, mem_b_addr}, '0);
        start = 1'b0;
        n = DONE_CYC + 2;
        found = 1'b0;
        while (n <= 600 && !found) begin
            if (done === 1'b1) found = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("held_second_done", n, 2 * DONE_CYC + 1);
        repeat (3) @(negedge clk);
        chk("held_all_writes_seen", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Sequences one N x N signed matrix multiply C = A x B across three single-port memory banks (MEM_A, MEM_B read-only; MEM_C write-only) and owns the MAC datapath.
- Sits under the top-level controller. The top level pulses start; this block walks i/j/k, drives the bank addresses, accumulates, writes each C element, then pulses done.
- Row-major storage in every bank: element (r,c) lives at address r*N+c.

Parameters:
- N, 64, matrix dimension (power of two, 2..64)
- ADDR_W, 12, bank address width; must equal log2(N*N)
- DATA_W, 8, A/B element width, signed two's complement
- ACC_W, 22, C element / accumulator width, signed

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  reset; synchronous, active-high (1 = reset), sampled on rising clk
- start  in  1  level, sampled only in IDLE
- busy  out  1  high in RUN/DRAIN/WRITE
- done  out  1  one-cycle pulse after the final C write
- mem_a_rd_en  out  1  MEM_A read strobe
- mem_a_addr  out  ADDR_W  MEM_A read address
- mem_a_rdata  in  DATA_W  MEM_A data, valid 1 cycle after rd_en
- mem_b_rd_en  out  1  MEM_B read strobe
- mem_b_addr  out  ADDR_W  MEM_B read address
- mem_b_rdata  in  DATA_W  MEM_B data, valid 1 cycle after rd_en
- mem_c_wr_en  out  1  MEM_C write strobe
- mem_c_addr  out  ADDR_W  MEM_C write address
- mem_c_wdata  out  ACC_W  MEM_C write data

Behaviour:
- Reset (rstn=1 at an edge):
  - state forced to IDLE; i, j, k, accumulator and pipeline-valid flag cleared.
  - All outputs 0 from the following cycle.
  - Applies from any state. A reset mid-run abandons the run: no further MEM_C write and no done pulse.
- States:
  - IDLE: start=1 → RUN with i=j=k=0. start=0 → stay.
  - RUN: lasts N cycles. In cycle k, rd_en (both banks)=1, mem_a_addr=i*N+k, mem_b_addr=k*N+j. After k=N-1 → DRAIN.
  - DRAIN: 1 cycle, no reads. Accumulates the data for k=N-1. → WRITE.
  - WRITE: 1 cycle. mem_c_wr_en=1, mem_c_addr=i*N+j, mem_c_wdata=accumulator.
    - If (i,j)=(N-1,N-1) → DONE.
    - Otherwise advance j (on j wrap to 0, increment i), clear k, → RUN.
  - DONE: 1 cycle with done=1, then → IDLE.
- Read pipeline: data requested in cycle t is consumed at the end of cycle t+1 via a registered valid flag carrying k.
- Accumulate: for returned k=0, acc <= product; otherwise acc <= acc + product.
- Arithmetic:
  - product = signed DATA_W x signed DATA_W, 2*DATA_W bits, sign-extended to ACC_W.
  - Accumulator wraps modulo 2^ACC_W; no saturation.
  - At the defaults, the worst-case sum (-128 x -128 x 64 = 1048576) fits without wrap.
- Timing: N+2 cycles per C element; no overlap between elements.
  - With the start-sampling edge as cycle 0, the last write occurs in cycle N*N*(N+2) and done=1 in cycle N*N*(N+2)+1.
  - N=64: done in cycle 270337.
- start: ignored outside IDLE. If start is still high when DONE returns to IDLE, a new run begins at the next edge. Before that edge, the bank contents are the user's responsibility.
- Strobe rule: rd_en and wr_en are never simultaneously high. Address outputs are don't-care while their strobe is low; the bench shall not check them then.
- Every C address 0..N*N-1 is written exactly once per run, in increasing order.

Test Plan:
- N=4, A=identity, B[r][c]=r*4+c: start pulse → C equals B; 16 writes at addresses 0..15 in order; done pulses exactly once, in cycle 97; busy falls in the same cycle.
- N=4, all A and B elements = -128: every C element = 65536 (0x010000). A=-128, B=127 everywhere → every C element = -65024 (0x3F0200 as 22-bit).
- N=64, random signed A/B against a golden model: all 4096 C words match. Default extremes A=B=-128 → 0x100000 everywhere.
- start re-pulsed during RUN and WRITE: the run is unaffected; done occurs exactly once, in the nominal cycle.
- rstn=1 for one cycle during the WRITE of element 5 (N=4): no write in the next cycle; busy=0, done=0; a new start completes a full run with correct C.
- start held high continuously: back-to-back runs; after done, a new RUN begins 2 cycles later with k=0 reads at address 0.
